alu16_activity_monitor: RTL and testbench
=========================================

// Module: alu16_activity_monitor
// PURPOSE
//  In-silicon counterpart of the ALU CSV logging bench. Sits beside alu16_ripple/alu16_cla
//  and observes each ALU result. Per opcode it accumulates the sample count, the summed
//  output toggles (popcount(y ^ prev_y)) and the peak toggles.
//  On request it streams one record per opcode out over a valid/ready port, where the bench
//  previously wrote CSV rows.
// PARAMETERS
//  DATA_W  16  ALU result width observed
//  OP_W    4   opcode width; NUM_OPS = 2**OP_W bank entries
//  CNT_W   24  per-opcode sample counter width (saturating)
//  SUM_W   32  per-opcode toggle-sum width (saturating)
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  clear      in   1       sync: zero bank and prev_y, abort dump
//  smp_valid  in   1       ALU sample valid this cycle (no backpressure, always accepted)
//  smp_op     in   OP_W    opcode s of the sample
//  smp_y      in   DATA_W  ALU yout of the sample
//  dump_start in   1       pulse: begin streaming all NUM_OPS records
//  dump_busy  out  1       high from dump_start accept until last record accepted
//  rec_valid  out  1       record valid
//  rec_ready  in   1       consumer ready
//  rec_op     out  OP_W    record opcode
//  rec_count  out  CNT_W   samples seen for rec_op
//  rec_tsum   out  SUM_W   summed toggles for rec_op
//  rec_tmax   out  5       peak toggles for rec_op (0..16)
// BEHAVIOUR
//  Reset: all outputs 0, bank 0, prev_y 0, FSM IDLE.
//  Sample pipe:
//   - S1 registers op and tog = popcount(smp_y ^ prev_y). prev_y <= smp_y on every valid sample (global, not per op).
//   - S2 does read-modify-write of bank[op]: count+1, tsum+tog, tmax=max(tmax,tog).
//   - Accept at edge N, visible in the bank after edge N+2.
//  Bank is flip-flops, so back-to-back samples to the same op need no stall; every sample is counted.
//  Saturation: count and tsum stick at all-ones and do not wrap.
//  Dump FSM IDLE -> LOAD -> SEND -> (LOAD|IDLE):
//   - IDLE: dump_start=1 -> LOAD, idx=0, dump_busy=1. dump_start ignored outside IDLE.
//   - LOAD: snapshot bank[idx] into the rec_* regs and set rec_valid=1 -> SEND (1 cycle).
//   - SEND: hold rec_* stable while rec_valid && !rec_ready. On handshake: if idx==NUM_OPS-1,
//     drop rec_valid and dump_busy and go to IDLE; else idx+1 and go to LOAD. One bubble per record.
//  Snapshot semantics: the record reflects the bank at the LOAD cycle. Samples keep accumulating during
//  a dump and are not reflected in an already-loaded record.
//  Simultaneous S2 write and LOAD to the same idx: LOAD sees the pre-update value.
//  clear: next edge zeroes bank and prev_y, flushes S1/S2, FSM->IDLE, rec_valid=0, dump_busy=0.
//   - An in-flight record is dropped; this is the only permitted valid-without-handshake deassert.
//   - clear with smp_valid: the sample is discarded.
//   - clear with dump_start: clear wins.
//  Async reset mid-dump or mid-sample: identical to reset state, no partial records.
// STRUCTURE
//  alu16_mon_pkg: OP_W, NUM_OPS, DATA_W, CNT_W, SUM_W, TMAX_W=5, FSM state enum,
//   and the popcount function.
//  Sub-module alu16_toggle_cnt: prev_y register + XOR + popcount + S1 register (outputs tog, op, vld).
//  Top holds the bank, saturating RMW (S2) and the dump FSM.
// TESTING
//  1. Reset, then samples op=3 y=0xFFFF then op=3 y=0x0000, dump_start, rec_ready=1
//     -> rec op3: count=2, tsum=32, tmax=16; all other ops count=0.
//  2. Back-to-back smp_valid 5 cycles, op=7, y alternating 0x0001/0x0000
//     -> op7 count=5, tsum=5, tmax=1 (no lost RMW).
//  3. Dump with rec_ready low 3 cycles on record 4 -> rec_* stable, rec_valid high throughout;
//     16 records total, op 0..15 in order, dump_busy drops after op15 handshake.
//  4. Preload op2 to count=10, dump; at op2 LOAD cycle inject op2 sample
//     -> record shows count=10; second dump shows 11.
//  5. Force op1 tsum to all-ones minus 3, then sample with tog=16 -> tsum=0xFFFFFFFF, no wrap.
//  6. Mid-dump (record 6 valid) assert clear -> rec_valid=0, dump_busy=0 next cycle;
//     new dump shows all zeros; repeat with rst_n low mid-dump -> same result.

Source files
------------

// File: rtl/alu16_mon_pkg.sv
// Shared widths, dump FSM encoding and the popcount helper for the ALU activity monitor.
package alu16_mon_pkg;

    localparam int DATA_W  = 16;
    localparam int OP_W    = 4;
    localparam int NUM_OPS = 2 ** OP_W;
    localparam int CNT_W   = 24;
    localparam int SUM_W   = 32;
    localparam int TMAX_W  = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } dump_state_t;

    // Number of set bits in an ALU-width word (0..DATA_W fits in TMAX_W bits).
    function automatic logic [TMAX_W-1:0] popcount(input logic [DATA_W-1:0] v);
        logic [TMAX_W-1:0] n;
        n = '0;
        for (int i = 0; i < DATA_W; i++) begin
            n = n + TMAX_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/alu16_toggle_cnt.sv
// First sample stage: keeps the previous ALU result (shared by all opcodes) and
// registers the opcode together with the number of bits that flipped.
module alu16_toggle_cnt
    import alu16_mon_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              smp_valid,
    input  logic [OP_W-1:0]   smp_op,
    input  logic [DATA_W-1:0] smp_y,
    output logic [TMAX_W-1:0] tog,
    output logic [OP_W-1:0]   op,
    output logic              vld
);

    logic [DATA_W-1:0] prev_y;
    logic [TMAX_W-1:0] tog_p1;
    logic [OP_W-1:0]   op_p1;
    logic              vld_p1;

    // ---- stage p0 -> p1 boundary ----
    // Control: S1 valid flag and the global previous-result register; clear drops the sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            prev_y <= '0;
        end else if (clear) begin
            vld_p1 <= 1'b0;
            prev_y <= '0;
        end else begin
            vld_p1 <= smp_valid;
            if (smp_valid) begin
                prev_y <= smp_y;
            end
        end
    end

    // Data: opcode and toggle count, only meaningful while vld_p1 is set.
    always_ff @(posedge clk) begin
        if (smp_valid) begin
            op_p1  <= smp_op;
            tog_p1 <= popcount(smp_y ^ prev_y);
        end
    end

    assign tog = tog_p1;
    assign op  = op_p1;
    assign vld = vld_p1;

endmodule

// File: rtl/alu16_activity_monitor.sv
// Per-opcode ALU activity statistics (sample count, toggle sum, toggle peak) with a
// valid/ready record stream that dumps one record per opcode on request.
module alu16_activity_monitor
    import alu16_mon_pkg::*;
#(
    parameter int CNT_W = alu16_mon_pkg::CNT_W,
    parameter int SUM_W = alu16_mon_pkg::SUM_W
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              smp_valid,
    input  logic [OP_W-1:0]   smp_op,
    input  logic [DATA_W-1:0] smp_y,
    input  logic              dump_start,
    output logic              dump_busy,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [OP_W-1:0]   rec_op,
    output logic [CNT_W-1:0]  rec_count,
    output logic [SUM_W-1:0]  rec_tsum,
    output logic [TMAX_W-1:0] rec_tmax
);

    logic [TMAX_W-1:0] tog_p1;
    logic [OP_W-1:0]   op_p1;
    logic              vld_p1;

    logic [TMAX_W-1:0] tog_p2;
    logic [OP_W-1:0]   op_p2;
    logic              vld_p2;

    logic [CNT_W-1:0]  cnt_bank  [NUM_OPS];
    logic [SUM_W-1:0]  tsum_bank [NUM_OPS];
    logic [TMAX_W-1:0] tmax_bank [NUM_OPS];

    dump_state_t       state;
    logic [OP_W-1:0]   idx;

    // Counter increment that sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // Toggle accumulation that sticks at all-ones instead of wrapping.
    function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] s,
                                                 input logic [TMAX_W-1:0] t);
        logic [SUM_W:0] wide;
        wide = {1'b0, s} + (SUM_W + 1)'(t);
        return wide[SUM_W] ? '1 : wide[SUM_W-1:0];
    endfunction

    alu16_toggle_cnt u_toggle (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .smp_valid (smp_valid),
        .smp_op    (smp_op),
        .smp_y     (smp_y),
        .tog       (tog_p1),
        .op        (op_p1),
        .vld       (vld_p1)
    );

    // ---- stage p1 -> p2 boundary ----
    // Control: S2 valid, flushed by clear so an in-flight sample never lands in the bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2 <= 1'b0;
        end else if (clear) begin
            vld_p2 <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
        end
    end

    // Data: opcode and toggle count carried into the bank update stage.
    always_ff @(posedge clk) begin
        if (vld_p1) begin
            op_p2  <= op_p1;
            tog_p2 <= tog_p1;
        end
    end

    // ---- stage p2 -> bank boundary ----
    // Read-modify-write of one bank entry per cycle; flops make back-to-back same-op updates safe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_OPS; i++) begin
                cnt_bank[i]  <= '0;
                tsum_bank[i] <= '0;
                tmax_bank[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < NUM_OPS; i++) begin
                cnt_bank[i]  <= '0;
                tsum_bank[i] <= '0;
                tmax_bank[i] <= '0;
            end
        end else if (vld_p2) begin
            cnt_bank[op_p2]  <= sat_inc(cnt_bank[op_p2]);
            tsum_bank[op_p2] <= sat_add(tsum_bank[op_p2], tog_p2);
            tmax_bank[op_p2] <= (tog_p2 > tmax_bank[op_p2]) ? tog_p2 : tmax_bank[op_p2];
        end
    end

    // Dump sequencer: snapshot one bank entry, hold it until accepted, step to the next opcode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            dump_busy <= 1'b0;
            rec_valid <= 1'b0;
            rec_op    <= '0;
            rec_count <= '0;
            rec_tsum  <= '0;
            rec_tmax  <= '0;
        end else if (clear) begin
            state     <= ST_IDLE;
            idx       <= '0;
            dump_busy <= 1'b0;
            rec_valid <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (dump_start) begin
                        state     <= ST_LOAD;
                        idx       <= '0;
                        dump_busy <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    // Bank reads here see the value before any same-cycle S2 write.
                    rec_op    <= idx;
                    rec_count <= cnt_bank[idx];
                    rec_tsum  <= tsum_bank[idx];
                    rec_tmax  <= tmax_bank[idx];
                    rec_valid <= 1'b1;
                    state     <= ST_SEND;
                end
                ST_SEND: begin
                    if (rec_ready) begin
                        rec_valid <= 1'b0;
                        if (idx == OP_W'(NUM_OPS - 1)) begin
                            dump_busy <= 1'b0;
                            state     <= ST_IDLE;
                        end else begin
                            idx   <= idx + OP_W'(1);
                            state <= ST_LOAD;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu16_activity_monitor.sv
// Bench for alu16_activity_monitor: directed table, multi-cycle corner sequences and
// randomized samples against a per-opcode statistics model.
module tb_alu16_activity_monitor;
    import alu16_mon_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        smp_valid;
    logic [3:0]  smp_op;
    logic [15:0] smp_y;
    logic        dump_start;
    logic        rec_ready;

    logic        dump_busy, rec_valid;
    logic [3:0]  rec_op;
    logic [23:0] rec_count;
    logic [31:0] rec_tsum;
    logic [4:0]  rec_tmax;

    // narrow-counter instance so saturation is reachable in a short run
    logic        s_dump_busy, s_rec_valid;
    logic [3:0]  s_rec_op;
    logic [3:0]  s_rec_count;
    logic [7:0]  s_rec_tsum;
    logic [4:0]  s_rec_tmax;

    always #5 clk = ~clk;

    alu16_activity_monitor dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .smp_valid(smp_valid), .smp_op(smp_op),
        .smp_y(smp_y), .dump_start(dump_start), .dump_busy(dump_busy), .rec_valid(rec_valid),
        .rec_ready(rec_ready), .rec_op(rec_op), .rec_count(rec_count), .rec_tsum(rec_tsum),
        .rec_tmax(rec_tmax)
    );

    alu16_activity_monitor #(.CNT_W(4), .SUM_W(8)) dut_sat (
        .clk(clk), .rst_n(rst_n), .clear(clear), .smp_valid(smp_valid), .smp_op(smp_op),
        .smp_y(smp_y), .dump_start(dump_start), .dump_busy(s_dump_busy), .rec_valid(s_rec_valid),
        .rec_ready(rec_ready), .rec_op(s_rec_op), .rec_count(s_rec_count), .rec_tsum(s_rec_tsum),
        .rec_tmax(s_rec_tmax)
    );

    int checks = 0;
    int errors = 0;

    // model state and snapshots
    longint m_cnt[NUM_OPS], m_tsum[NUM_OPS], m_tmax[NUM_OPS];
    logic [15:0] m_prev;
    longint x_cnt[NUM_OPS], x_tsum[NUM_OPS], x_tmax[NUM_OPS];
    longint g_op[NUM_OPS], g_cnt[NUM_OPS], g_tsum[NUM_OPS], g_tmax[NUM_OPS];
    longint gs_cnt[NUM_OPS], gs_tsum[NUM_OPS], gs_tmax[NUM_OPS];
    longint e_cnt[NUM_OPS], e_tsum[NUM_OPS], e_tmax[NUM_OPS];

    typedef struct {
        logic [3:0]  op;
        logic [15:0] y;
        longint      cnt;
        longint      tsum;
        longint      tmax;
    } vec_t;
    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NUM_OPS; i++) begin
            m_cnt[i] = 0; m_tsum[i] = 0; m_tmax[i] = 0;
        end
        m_prev = 16'h0000;
    endtask

    task automatic model_sample(input logic [3:0] op, input logic [15:0] y);
        longint tog;
        tog = longint'($countones(y ^ m_prev));
        m_prev = y;
        m_cnt[op]  = (m_cnt[op] + 1 > 64'hFF_FFFF) ? 64'hFF_FFFF : m_cnt[op] + 1;
        m_tsum[op] = (m_tsum[op] + tog > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_tsum[op] + tog;
        if (tog > m_tmax[op]) m_tmax[op] = tog;
    endtask

    task automatic send_sample(input logic [3:0] op, input logic [15:0] y);
        smp_valid = 1'b1; smp_op = op; smp_y = y;
        model_sample(op, y);
        step();
        smp_valid = 1'b0;
    endtask

    task automatic drain();
        smp_valid = 1'b0;
        repeat (3) step();
    endtask

    task automatic clear_all();
        clear = 1'b1;
        step();
        clear = 1'b0;
        model_clear();
    endtask

    task automatic rand_samples(input int n);
        logic v;
        logic [3:0] op;
        logic [15:0] y;
        for (int k = 0; k < n; k++) begin
            v  = ($urandom_range(0, 3) != 0);
            op = 4'($urandom_range(0, 15));
            y  = ($urandom_range(0, 1) != 0) ? 16'($urandom) : (m_prev ^ (16'h1 << $urandom_range(0, 15)));
            smp_valid = v; smp_op = op; smp_y = y;
            if (v) model_sample(op, y);
            step();
        end
        smp_valid = 1'b0;
    endtask

    // Runs one dump, capturing each accepted record. Optional: stall a record three cycles,
    // inject a sample in the LOAD cycle of an opcode, or abort by clear / async reset.
    task automatic do_dump(input int stall_op, input int inject_op, input int abort_op,
                           input bit abort_rst, input bit rand_ready);
        int n, stall_left;
        bit held_open, inj_next;
        logic [3:0] h_op; logic [23:0] h_cnt; logic [31:0] h_tsum; logic [4:0] h_tmax;
        n = 0; stall_left = 3; held_open = 1'b0; inj_next = 1'b0;
        for (int i = 0; i < NUM_OPS; i++) begin
            x_cnt[i] = m_cnt[i]; x_tsum[i] = m_tsum[i]; x_tmax[i] = m_tmax[i];
        end
        rec_ready = 1'b0;
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        check("dump_busy after start", dump_busy, 1);
        for (int cyc = 0; cyc < 300 && n < NUM_OPS; cyc++) begin
            smp_valid = 1'b0;
            if (inj_next) begin
                smp_valid = 1'b1; smp_op = inject_op[3:0]; smp_y = 16'h0000;
                model_sample(inject_op[3:0], 16'h0000);
                inj_next = 1'b0;
            end
            rec_ready = 1'b0;
            if (held_open) begin
                check("stall rec_valid", rec_valid, 1);
                check("stall rec_op", rec_op, h_op);
                check("stall rec_count", rec_count, h_cnt);
                check("stall rec_tsum", rec_tsum, h_tsum);
                check("stall rec_tmax", rec_tmax, h_tmax);
            end
            if (rec_valid) begin
                if (abort_op >= 0 && int'(rec_op) == abort_op) begin
                    smp_valid = 1'b1; smp_op = 4'd9; smp_y = 16'hFFFF;
                    if (!abort_rst) begin
                        clear = 1'b1;
                        step();
                        clear = 1'b0;
                        smp_valid = 1'b0;
                    end else begin
                        #2 rst_n = 1'b0;
                        #1 smp_valid = 1'b0;
                        check("abort rst rec_op", rec_op, 0);
                        check("abort rst rec_count", rec_count, 0);
                    end
                    check("abort rec_valid", rec_valid, 0);
                    check("abort dump_busy", dump_busy, 0);
                    if (abort_rst) begin
                        @(posedge clk);
                        #1 rst_n = 1'b1;
                    end
                    step();
                    check("abort rec_valid later", rec_valid, 0);
                    model_clear();
                    return;
                end
                if (stall_op >= 0 && int'(rec_op) == stall_op && stall_left > 0) begin
                    if (stall_left == 3) begin
                        held_open = 1'b1;
                        h_op = rec_op; h_cnt = rec_count; h_tsum = rec_tsum; h_tmax = rec_tmax;
                    end
                    if (stall_left == 2) dump_start = 1'b1;
                    stall_left--;
                    rec_ready = 1'b0;
                end else begin
                    rec_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
                end
                if (rec_ready) begin
                    g_op[n] = rec_op; g_cnt[n] = rec_count; g_tsum[n] = rec_tsum; g_tmax[n] = rec_tmax;
                    gs_cnt[n] = s_rec_count; gs_tsum[n] = s_rec_tsum; gs_tmax[n] = s_rec_tmax;
                    if (inject_op > 0 && int'(rec_op) == inject_op - 1) inj_next = 1'b1;
                    held_open = 1'b0;
                    n++;
                end
            end
            step();
            dump_start = 1'b0;
        end
        rec_ready = 1'b0;
        smp_valid = 1'b0;
        check("dump record count", n, NUM_OPS);
        check("dump_busy after last", dump_busy, 0);
        check("rec_valid after last", rec_valid, 0);
    endtask

    task automatic compare_snap(input string tag);
        for (int i = 0; i < NUM_OPS; i++) begin
            check($sformatf("%s op%0d order", tag, i), g_op[i], i);
            check($sformatf("%s op%0d count", tag, i), g_cnt[i], x_cnt[i]);
            check($sformatf("%s op%0d tsum", tag, i), g_tsum[i], x_tsum[i]);
            check($sformatf("%s op%0d tmax", tag, i), g_tmax[i], x_tmax[i]);
        end
    endtask

    initial begin
        // op, y, cumulative count/tsum/tmax for that op after the sample
        vecs[0]  = '{4'd3,  16'hFFFF, 1, 16, 16};
        vecs[1]  = '{4'd3,  16'h0000, 2, 32, 16};
        vecs[2]  = '{4'd7,  16'h0001, 1, 1, 1};
        vecs[3]  = '{4'd7,  16'h0000, 2, 2, 1};
        vecs[4]  = '{4'd7,  16'h0001, 3, 3, 1};
        vecs[5]  = '{4'd7,  16'h0000, 4, 4, 1};
        vecs[6]  = '{4'd7,  16'h0001, 5, 5, 1};
        vecs[7]  = '{4'd0,  16'h00FF, 1, 7, 7};
        vecs[8]  = '{4'd0,  16'h0F0F, 2, 15, 8};
        vecs[9]  = '{4'd0,  16'h0F0E, 3, 16, 8};
        vecs[10] = '{4'd15, 16'h8000, 1, 8, 8};
        vecs[11] = '{4'd3,  16'h7FFF, 3, 48, 16};

        rst_n = 1'b0; clear = 1'b0; smp_valid = 1'b0; smp_op = '0; smp_y = '0;
        dump_start = 1'b0; rec_ready = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        check("reset dump_busy", dump_busy, 0);
        check("reset rec_valid", rec_valid, 0);
        check("reset rec_op", rec_op, 0);
        check("reset rec_count", rec_count, 0);
        check("reset rec_tsum", rec_tsum, 0);
        check("reset rec_tmax", rec_tmax, 0);
        check("reset sat rec_valid", s_rec_valid, 0);

        // table applied back-to-back, then a dump that stalls record 4 and pokes dump_start
        for (int i = 0; i < NUM_OPS; i++) begin
            e_cnt[i] = 0; e_tsum[i] = 0; e_tmax[i] = 0;
        end
        for (int i = 0; i < 12; i++) begin
            send_sample(vecs[i].op, vecs[i].y);
            e_cnt[vecs[i].op] = vecs[i].cnt;
            e_tsum[vecs[i].op] = vecs[i].tsum;
            e_tmax[vecs[i].op] = vecs[i].tmax;
        end
        drain();
        do_dump(4, -1, -1, 1'b0, 1'b0);
        for (int i = 0; i < NUM_OPS; i++) begin
            check($sformatf("tbl op%0d order", i), g_op[i], i);
            check($sformatf("tbl op%0d count", i), g_cnt[i], e_cnt[i]);
            check($sformatf("tbl op%0d tsum", i), g_tsum[i], e_tsum[i]);
            check($sformatf("tbl op%0d tmax", i), g_tmax[i], e_tmax[i]);
        end

        // snapshot vs sample landing during the op2 LOAD cycle
        clear_all();
        for (int k = 0; k < 10; k++) send_sample(4'd2, 16'h0000);
        drain();
        do_dump(-1, 2, -1, 1'b0, 1'b0);
        compare_snap("inject1");
        check("inject first dump op2 count", g_cnt[2], 10);
        drain();
        do_dump(-1, -1, -1, 1'b0, 1'b0);
        compare_snap("inject2");
        check("inject second dump op2 count", g_cnt[2], 11);

        // saturation: narrow instance reaches its limits, wide instance follows the model
        clear_all();
        for (int k = 0; k < 15; k++) send_sample(4'd1, (k % 2 == 0) ? 16'hFFFF : 16'h0000);
        send_sample(4'd1, 16'hF000);
        drain();
        do_dump(-1, -1, -1, 1'b0, 1'b0);
        compare_snap("sat pre");
        check("sat pre count", gs_cnt[1], 15);
        check("sat pre tsum", gs_tsum[1], 252);
        check("sat pre tmax", gs_tmax[1], 16);
        send_sample(4'd1, 16'h0FFF);
        drain();
        do_dump(-1, -1, -1, 1'b0, 1'b0);
        compare_snap("sat post");
        check("sat post count", gs_cnt[1], 15);
        check("sat post tsum", gs_tsum[1], 255);
        check("sat post tmax", gs_tmax[1], 16);

        // randomized traffic with random consumer backpressure
        clear_all();
        rand_samples(300);
        drain();
        do_dump(-1, -1, -1, 1'b0, 1'b1);
        compare_snap("rand1");
        rand_samples(300);
        drain();
        do_dump(-1, -1, -1, 1'b0, 1'b1);
        compare_snap("rand2");

        // clear mid-dump (with a sample that must be discarded), then async reset mid-dump
        rand_samples(40);
        drain();
        do_dump(-1, -1, 6, 1'b0, 1'b0);
        send_sample(4'd5, 16'h0000);
        drain();
        do_dump(-1, -1, -1, 1'b0, 1'b0);
        compare_snap("after clear");
        check("after clear op5 count", g_cnt[5], 1);
        check("after clear op5 tsum", g_tsum[5], 0);
        rand_samples(40);
        drain();
        do_dump(-1, -1, 6, 1'b1, 1'b0);
        do_dump(-1, -1, -1, 1'b0, 1'b0);
        compare_snap("after rst");
        check("after rst op9 count", g_cnt[9], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
